// File: rtl/image_stream_reader_if.sv
// Bundle of the reader's control, RAM-port and pixel-stream signals.
// The master modport is the reader; the slave modport is the RAM/consumer side.
interface image_stream_reader_if #(
    parameter int RAM_WIDTH     = 24,
    parameter int RAM_ADDR_BITS = 16
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [RAM_ADDR_BITS-1:0] mem_addr;
    logic                     mem_we;
    logic [RAM_WIDTH-1:0]     mem_di;
    logic [RAM_WIDTH-1:0]     mem_do;
    logic [RAM_WIDTH-1:0]     pix_data;
    logic                     pix_valid;
    logic                     pix_ready;
    logic                     pix_sof;
    logic                     pix_eol;
    logic                     pix_eof;

    modport master (
        input  start, mem_do, pix_ready,
        output busy, done, mem_addr, mem_we, mem_di,
               pix_data, pix_valid, pix_sof, pix_eol, pix_eof
    );

    modport slave (
        output start, mem_do, pix_ready,
        input  busy, done, mem_addr, mem_we, mem_di,
               pix_data, pix_valid, pix_sof, pix_eol, pix_eof
    );
endinterface

// File: rtl/image_stream_reader.sv
// Raster-scan reader: walks one IMG_W x IMG_H frame out of a single-port
// RAM with a 1-cycle registered read and streams it on valid/ready with
// sof/eol/eof markers. A 2-entry FIFO absorbs the read latency so that
// backpressure never drops or repeats a pixel.
module image_stream_reader #(
    parameter int RAM_WIDTH     = 24,
    parameter int RAM_ADDR_BITS = 16,
    parameter int IMG_W         = 320,
    parameter int IMG_H         = 240,
    parameter int BASE_ADDR     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    image_stream_reader_if.master bus
);
    localparam int TOTAL = IMG_W * IMG_H;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int XW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [RAM_ADDR_BITS-1:0] BASE      = RAM_ADDR_BITS'(BASE_ADDR);
    localparam logic [CNT_W-1:0]         LAST_CNT  = CNT_W'(TOTAL - 1);
    localparam logic [XW-1:0]            LAST_X    = XW'(IMG_W - 1);
    localparam logic [YW-1:0]            LAST_Y    = YW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state_reg;
    logic [RAM_ADDR_BITS-1:0] addr_reg;
    logic                     rd_pending_reg;
    logic [CNT_W-1:0]         issue_cnt_reg;
    logic [XW-1:0]            x_out_reg;
    logic [YW-1:0]            y_out_reg;
    logic                     done_reg;

    logic [RAM_WIDTH-1:0]     fifo_mem [0:1];
    logic                     wr_ptr_reg;
    logic                     rd_ptr_reg;
    logic [1:0]               fifo_count_reg;

    logic                     pix_valid;
    logic                     pop;
    logic                     push;
    logic [2:0]               occupancy;
    logic                     issue;
    logic                     last_issue;
    logic                     at_eol;
    logic                     at_eof;

    // Issue decision: keep FIFO entries plus the read in flight at most 2,
    // counting the slot freed by a pop in this same cycle.
    always_comb begin
        pix_valid  = (fifo_count_reg != 2'd0);
        pop        = pix_valid && bus.pix_ready;
        push       = rd_pending_reg;
        occupancy  = {1'b0, fifo_count_reg} + {2'b00, rd_pending_reg} - {2'b00, pop};
        issue      = (state_reg == RUN) && (occupancy < 3'd2);
        last_issue = issue && (issue_cnt_reg == LAST_CNT);
        at_eol     = (x_out_reg == LAST_X);
        at_eof     = at_eol && (y_out_reg == LAST_Y);
    end

    // Control FSM, address generator and output position counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_reg       <= BASE;
            rd_pending_reg <= 1'b0;
            issue_cnt_reg  <= '0;
            x_out_reg      <= '0;
            y_out_reg      <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg       <= 1'b0;
            rd_pending_reg <= issue;

            if (issue) begin
                issue_cnt_reg <= issue_cnt_reg + CNT_W'(1);
                // The final address is held so no read runs past the frame.
                if (!last_issue)
                    addr_reg <= addr_reg + RAM_ADDR_BITS'(1);
            end

            if (pop) begin
                if (at_eol) begin
                    x_out_reg <= '0;
                    y_out_reg <= at_eof ? '0 : y_out_reg + YW'(1);
                end else begin
                    x_out_reg <= x_out_reg + XW'(1);
                end
            end

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg     <= RUN;
                        addr_reg      <= BASE;
                        issue_cnt_reg <= '0;
                        x_out_reg     <= '0;
                        y_out_reg     <= '0;
                    end
                end
                RUN: begin
                    if (last_issue)
                        state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (pop && at_eof) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Two-entry pixel FIFO; push only for reads that were actually issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++)
                fifo_mem[i] <= '0;
            wr_ptr_reg     <= 1'b0;
            rd_ptr_reg     <= 1'b0;
            fifo_count_reg <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= bus.mem_do;
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            fifo_count_reg <= fifo_count_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = done_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_di    = '0;
    assign bus.pix_valid = pix_valid;
    assign bus.pix_data  = fifo_mem[rd_ptr_reg];
    assign bus.pix_sof   = pix_valid && (x_out_reg == '0) && (y_out_reg == '0);
    assign bus.pix_eol   = pix_valid && at_eol;
    assign bus.pix_eof   = pix_valid && at_eof;
endmodule
